// File: rtl/uart_mem_loader_if.sv
// Byte-stream and RAM-port bundle between the UART loader and its neighbours.
// master is the loader side; slave is the UART/RAM side.
interface uart_mem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [12:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  modport master (
    input  rx_data, rx_valid, tx_ready, ram_rdata,
    output tx_data, tx_valid, ram_addr, ram_wdata, ram_we
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, ram_rdata,
    input  tx_data, tx_valid, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/uart_mem_loader.sv
// Framed WRITE/READ/RUN command responder between the UART byte stream and the
// program RAM; answers with ACK/NAK and read data, and releases the core on RUN.
module uart_mem_loader #(
  parameter int CLK_FREQ   = 60000000,
  parameter int TIMEOUT_US = 1000
) (
  input  logic               clk,
  input  logic               rst,
  uart_mem_loader_if.master  bus,
  output logic               core_run,
  output logic               busy,
  output logic [7:0]         err_count
);

  localparam int TIMEOUT_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] BYTE_WRITE = 8'hA5;
  localparam logic [7:0] BYTE_READ  = 8'h5A;
  localparam logic [7:0] BYTE_RUN   = 8'hC3;
  localparam logic [7:0] BYTE_ACK   = 8'h06;
  localparam logic [7:0] BYTE_NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, DATA, CSUM, EXEC, RESP
  } state_e;

  typedef enum logic [1:0] {
    CMD_WRITE, CMD_READ, CMD_RUN
  } cmd_e;

  state_e        state_q, state_d;
  cmd_e          cmd_q, cmd_d;
  logic [7:0]    csum_q, csum_d;
  logic [4:0]    addr_hi_q, addr_hi_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [1:0]    wait_cnt_q, wait_cnt_d;
  logic [31:0]   rd_word_q, rd_word_d;
  logic [2:0]    tx_left_q, tx_left_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [12:0]   ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic          ram_we_q, ram_we_d;
  logic          core_run_q, core_run_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_inc;
  logic          in_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= CMD_WRITE;
      csum_q      <= '0;
      addr_hi_q   <= '0;
      byte_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      rd_word_q   <= '0;
      tx_left_q   <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      core_run_q  <= 1'b0;
      err_count_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      csum_q      <= csum_d;
      addr_hi_q   <= addr_hi_d;
      byte_cnt_q  <= byte_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      rd_word_q   <= rd_word_d;
      tx_left_q   <= tx_left_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      core_run_q  <= core_run_d;
      err_count_q <= err_count_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign in_frame = (state_q == ADDR_HI) || (state_q == ADDR_LO) ||
                    (state_q == DATA)    || (state_q == CSUM);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    csum_d      = csum_q;
    addr_hi_d   = addr_hi_q;
    byte_cnt_d  = byte_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    rd_word_d   = rd_word_q;
    tx_left_d   = tx_left_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    core_run_d  = core_run_q;
    tmo_cnt_d   = '0;
    err_inc     = 1'b0;

    // Timeout only fires on a silent cycle, so it never collides with a byte below.
    if (in_frame && !bus.rx_valid) begin
      if (tmo_cnt_q == TMO_LAST) begin
        state_d = IDLE;
        err_inc = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          csum_d = bus.rx_data;
          case (bus.rx_data)
            BYTE_WRITE: begin cmd_d = CMD_WRITE; state_d = ADDR_HI; end
            BYTE_READ:  begin cmd_d = CMD_READ;  state_d = ADDR_HI; end
            BYTE_RUN:   begin cmd_d = CMD_RUN;   state_d = CSUM;    end
            default:    csum_d = csum_q;
          endcase
        end
      end
      ADDR_HI: begin
        if (bus.rx_valid) begin
          addr_hi_d = bus.rx_data[4:0];
          csum_d    = csum_q ^ bus.rx_data;
          state_d   = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (bus.rx_valid) begin
          ram_addr_d = {addr_hi_q, bus.rx_data};
          csum_d     = csum_q ^ bus.rx_data;
          byte_cnt_d = '0;
          state_d    = (cmd_q == CMD_WRITE) ? DATA : CSUM;
        end
      end
      DATA: begin
        if (bus.rx_valid) begin
          ram_wdata_d = {ram_wdata_q[23:0], bus.rx_data};
          csum_d      = csum_q ^ bus.rx_data;
          byte_cnt_d  = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = CSUM;
        end
      end
      CSUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == csum_q) begin
            state_d    = EXEC;
            wait_cnt_d = '0;
            ram_we_d   = (cmd_q == CMD_WRITE);
          end else begin
            tx_data_d  = BYTE_NAK;
            tx_valid_d = 1'b1;
            tx_left_d  = '0;
            err_inc    = 1'b1;
            state_d    = RESP;
          end
        end
      end
      EXEC: begin
        case (cmd_q)
          CMD_READ: begin
            // RAM registers both address and q, so data lands two cycles in.
            if (wait_cnt_q == 2'd2) begin
              rd_word_d  = bus.ram_rdata;
              tx_data_d  = BYTE_ACK;
              tx_valid_d = 1'b1;
              tx_left_d  = 3'd4;
              state_d    = RESP;
            end else begin
              wait_cnt_d = wait_cnt_q + 2'd1;
            end
          end
          default: begin
            core_run_d = core_run_q | (cmd_q == CMD_RUN);
            tx_data_d  = BYTE_ACK;
            tx_valid_d = 1'b1;
            tx_left_d  = '0;
            state_d    = RESP;
          end
        endcase
      end
      RESP: begin
        if (tx_valid_q && bus.tx_ready) begin
          if (tx_left_q != 3'd0) begin
            tx_data_d = rd_word_q[31:24];
            rd_word_d = {rd_word_q[23:0], 8'h00};
            tx_left_d = tx_left_q - 3'd1;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    err_count_d = (err_inc && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;
  assign core_run      = core_run_q;
  assign busy          = (state_q != IDLE);
  assign err_count     = err_count_q;

endmodule
